dmem_responder: RTL

Multi-cycle data-memory responder that serves load/store requests from the CPU datapath over a valid/ready request channel and a valid/ready response channel. It replaces the single-cycle data memory with a handshaked slave that has configurable wait states, byte/half/word/double transfer sizes, and error reporting for misaligned or out-of-range accesses. It is the target the pipelined or multi-cycle core's memory stage initiates against.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU memory stage (master) and a
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed wait-state
// delay, registered response with size/alignment/range error reporting.
//
// state  | meaning
// S_IDLE | req_ready high, waiting for a request
// S_WAIT | request captured, down-counting wait states; commit at terminal count
// S_RESP | response registered and held until resp_ready
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  size_q, size_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Storage is deliberately left out of reset.
  logic [7:0]  mem_q [DEPTH_BYTES];

  logic          req_err;
  logic          mem_we;
  logic [AW-1:0] base;
  logic [63:0]   load_data;

  assign base = addr_q[AW-1:0];

  always_comb begin
    req_err = 1'b0;
    if (!(size_q inside {4'd1, 4'd2, 4'd4, 4'd8}))
      req_err = 1'b1;
    else if ((addr_q[3:0] & (size_q - 4'd1)) != 4'd0)
      req_err = 1'b1;
    if (addr_q >= 64'(DEPTH_BYTES))
      req_err = 1'b1;
  end

  always_comb begin
    load_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(size_q))
        load_data[8*k +: 8] = mem_q[base + AW'(k)];
    end
  end

  assign mem_we = (state_q == S_WAIT) && (cnt_q == 4'd0) && write_q && !req_err;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          resp_err_d   = req_err;
          resp_rdata_d = (write_q || req_err) ? 64'd0 : load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d      = S_IDLE;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // A reset during S_WAIT forces S_IDLE asynchronously, so a pending store never commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(size_q))
          mem_q[base + AW'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule
